fft_frame_sink: RTL and testbench
=================================

Name: fft_frame_sink

Overview:
Receive-side endpoint for the FFT core's streaming output (source_valid/sop/eop/error/exp/real/imag), the counterpart of the input-side framer that drives the core's sink_* interface.
- Validates frame framing.
- Computes per-bin power re²+im² in a 2-stage pipeline.
- Stores one frame in a dual-port buffer and tracks the peak bin.
- Holds the completed frame for readout until the consumer acknowledges it, back-pressuring the core via src_ready.

Parameters:
FFT_LEN, 256, points per frame (power of 2, ≥4)
DW, 12, width of signed real/imag samples
EXP_W, 6, width of block-exponent field
AW, $clog2(FFT_LEN), bin index / buffer address width (derived)

Ports:
sys_clk  in  1  system clock
sys_rst_n  in  1  asynchronous active-low reset
src_valid  in  1  beat valid from FFT core
src_ready  out  1  block can accept a beat (drives core's source_ready)
src_sop  in  1  first beat of frame
src_eop  in  1  last beat of frame
src_error  in  2  core error code; nonzero marks beat bad
src_exp  in  EXP_W  signed block exponent, sampled on sop beat
src_real  in  DW  signed real part
src_imag  in  DW  signed imaginary part
rd_en  in  1  buffer read strobe
rd_addr  in  AW  bin to read
rd_data  out  2*DW  unsigned power of bin rd_addr
rd_valid  out  1  rd_data valid
frame_done  out  1  one-cycle pulse: good frame stored
frame_ack  in  1  consumer releases held frame
peak_bin  out  AW  index of max-power bin of held frame
peak_pow  out  2*DW  power at peak_bin
frame_exp  out  EXP_W  exponent of held frame
err_flag  out  1  sticky framing/core error; cleared only by reset

Behaviour:
- Reset (async, any time, including mid-frame): state IDLE, beat counter 0, pipeline flushed. All outputs 0, including src_ready, err_flag, and the peak registers. Buffer contents undefined.
- Handshake: a beat transfers when src_valid && src_ready.
- src_ready is registered:
  - 1 from the first cycle after reset release while in IDLE/RECV.
  - 0 in HOLD.
- States:
  - IDLE: accepted beats without sop are dropped silently. A sop beat stores bin 0, latches the exponent, sets cnt=1, and goes to RECV. A sop+eop beat counts as a short frame (see below).
  - RECV: each beat writes bin cnt and increments cnt.
    - eop with cnt==FFT_LEN-1: frame good; go to DRAIN.
    - eop early: set err_flag, discard, go to IDLE.
    - sop mid-frame: set err_flag, abandon the old frame, restart at bin 0 with the new sop beat.
    - Last beat (cnt==FFT_LEN-1) without eop: set err_flag, discard, go to IDLE.
    - Any beat with src_error≠0: frame marked bad; on its eop, set err_flag and go to IDLE.
  - DRAIN: 2 cycles while the power pipeline retires. src_ready=0. Then frame_done pulses for 1 cycle and the state moves to HOLD.
  - HOLD: peak_bin/peak_pow/frame_exp are stable. frame_ack goes to IDLE next cycle with src_ready=1. A frame_ack in the same cycle frame_done pulses is honoured.
- Power pipeline:
  - Stage 1 registers re/im.
  - Stage 2 computes re²+im², unsigned 2*DW bits; (-2^(DW-1))² × 2 fits without overflow.
  - Buffer write at stage 2. Latency from beat to buffer write: 2 cycles.
- Peak tracking: running compare at stage 2. Strictly-greater replaces, so ties keep the lowest index. Bin 0 initialises the peak. Peak outputs update only on the frame_done pulse (shadow copy); discarded frames never alter them.
- Read port:
  - Synchronous: rd_valid and rd_data one cycle after rd_en.
  - Data is guaranteed to be the held frame only in HOLD. Reads in other states return undefined data with rd_valid still asserted.

Optional Feature:
DC_EXCLUDE_EN
- Defined: bin 0 is excluded from peak search. Bin 1 initialises the peak. Bin 0 is still stored and readable.
- Undefined: bin 0 participates normally.

Decomposition:
- Package fft_sink_pkg holds:
  - FFT_LEN/DW/EXP_W defaults.
  - State enum: IDLE, RECV, DRAIN, HOLD.
  - POW_W = 2*DW constant.
- Natural sub-module: fft_pow_calc, the 2-stage signed squarer/adder with valid/index/last sideband pipelined alongside the data.

Test Plan (bench overrides FFT_LEN=16, DW=12):
- Good frame, bin k has re=k, im=0 (k=0..15), exp=-3 → frame_done 2 cycles after the eop transfer; peak_bin=15, peak_pow=225, frame_exp=-3; rd_addr=7 gives rd_data=49 next cycle.
- Bin 5 = (-2048,-2048), all others 0 → peak_pow=8388608, peak_bin=5, no overflow.
- Bins 3 and 9 both (10,10), all others 0 → peak_bin=3 (tie keeps lowest index). Bin 0 = (100,0) with DC_EXCLUDE_EN defined → peak_bin≠0.
- eop on the 10th beat → err_flag=1, no frame_done, peak outputs unchanged; a following good frame completes normally.
- Good frame then a second frame offered in HOLD → src_ready=0 and no transfer until frame_ack; src_ready=1 the cycle after frame_ack.
- Reset asserted mid-RECV at beat 6 → all outputs 0 immediately; after release, a frame starting without sop is dropped and the next sop frame succeeds.

Source files
------------

// File: rtl/fft_sink_pkg.sv
// -----------------------------------------------------------------------------
// fft_sink_pkg
// Shared definitions for the FFT output sink: default geometry, the power word
// width and the frame-level state encoding.
// -----------------------------------------------------------------------------
package fft_sink_pkg;

   localparam int FFT_LEN_DEF = 256;
   localparam int DW_DEF      = 12;
   localparam int EXP_W_DEF   = 6;

   // re^2 + im^2 of two DW-bit signed values always fits in 2*DW unsigned bits.
   localparam int POW_W = 2 * DW_DEF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RECV  = 2'd1,
      DRAIN = 2'd2,
      HOLD  = 2'd3
   } sink_state_e;

endpackage : fft_sink_pkg

// File: rtl/fft_pow_calc.sv
// -----------------------------------------------------------------------------
// fft_pow_calc
// Two-stage power pipeline: stage 1 registers the complex sample, stage 2
// registers re^2 + im^2 as an unsigned 2*DW-bit word. The beat valid and bin
// index travel alongside the data so the result can be written straight into
// the frame buffer.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset (valids only)
//   in_vld, in_idx    beat valid / bin index entering stage 1
//   in_re, in_im      signed sample
//   out_vld, out_idx  valid / bin index leaving stage 2
//   out_pow           unsigned power, 2*DW bits
// -----------------------------------------------------------------------------
module fft_pow_calc #(
   parameter int DW = 12,
   parameter int AW = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_vld,
   input  logic [AW-1:0]        in_idx,
   input  logic signed [DW-1:0] in_re,
   input  logic signed [DW-1:0] in_im,
   output logic                 out_vld,
   output logic [AW-1:0]        out_idx,
   output logic [2*DW-1:0]      out_pow
);

   // Square of a signed sample. The widest case, (-2^(DW-1))^2 = 2^(2*DW-2),
   // is still positive in a 2*DW-bit signed word, so no bits are lost.
   function automatic logic [2*DW-1:0] square_u(input logic signed [DW-1:0] x);
      logic signed [2*DW-1:0] xw;
      logic signed [2*DW-1:0] sq;
      xw = {{DW{x[DW-1]}}, x};
      sq = xw * xw;
      return sq;
   endfunction

   logic                 vld_p1_q, vld_p1_d;
   logic [AW-1:0]        idx_p1_q, idx_p1_d;
   logic signed [DW-1:0] re_p1_q, re_p1_d;
   logic signed [DW-1:0] im_p1_q, im_p1_d;
   logic                 vld_p2_q, vld_p2_d;
   logic [AW-1:0]        idx_p2_q, idx_p2_d;
   logic [2*DW-1:0]      pow_p2_q, pow_p2_d;

   always_comb begin
      // stage 1: capture the accepted beat
      vld_p1_d = in_vld;
      idx_p1_d = in_idx;
      re_p1_d  = in_re;
      im_p1_d  = in_im;
      // stage 2: squares and sum (sum of two squares never exceeds 2^(2*DW-1))
      vld_p2_d = vld_p1_q;
      idx_p2_d = idx_p1_q;
      pow_p2_d = square_u(re_p1_q) + square_u(im_p1_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1_q <= 1'b0;
         vld_p2_q <= 1'b0;
      end else begin
         vld_p1_q <= vld_p1_d;
         vld_p2_q <= vld_p2_d;
      end
   end

   always_ff @(posedge clk) begin
      idx_p1_q <= idx_p1_d;
      re_p1_q  <= re_p1_d;
      im_p1_q  <= im_p1_d;
      idx_p2_q <= idx_p2_d;
      pow_p2_q <= pow_p2_d;
   end

   assign out_vld = vld_p2_q;
   assign out_idx = idx_p2_q;
   assign out_pow = pow_p2_q;

endmodule : fft_pow_calc

// File: rtl/fft_frame_sink.sv
// -----------------------------------------------------------------------------
// fft_frame_sink
// Receive-side endpoint for the FFT core's streaming output. Checks frame
// framing, computes per-bin power, stores one frame in a buffer, tracks the
// peak bin and holds the finished frame for readout until the consumer
// acknowledges it (src_ready is low while a frame is held).
//
// Build option
//   DC_EXCLUDE_EN  when defined, bin 0 is left out of the peak search (bin 1
//                  seeds the peak); bin 0 is still stored and readable.
//
// Ports
//   sys_clk, sys_rst_n    clock, asynchronous active-low reset
//   src_valid/src_ready   beat handshake with the FFT core
//   src_sop/src_eop       frame delimiters
//   src_error             nonzero marks the beat (and its frame) bad
//   src_exp               signed block exponent, taken on the sop beat
//   src_real/src_imag     signed sample
//   rd_en/rd_addr         synchronous buffer read request
//   rd_data/rd_valid      power of rd_addr, one cycle after rd_en
//   frame_done            one-cycle pulse when a good frame is held
//   frame_ack             consumer releases the held frame
//   peak_bin/peak_pow     peak of the held frame
//   frame_exp             exponent of the held frame
//   err_flag              sticky framing/core error, cleared only by reset
// -----------------------------------------------------------------------------
module fft_frame_sink
   import fft_sink_pkg::*;
#(
   parameter int FFT_LEN = FFT_LEN_DEF,
   parameter int DW      = DW_DEF,
   parameter int EXP_W   = EXP_W_DEF,
   parameter int AW      = $clog2(FFT_LEN)
) (
   input  logic                    sys_clk,
   input  logic                    sys_rst_n,
   input  logic                    src_valid,
   output logic                    src_ready,
   input  logic                    src_sop,
   input  logic                    src_eop,
   input  logic [1:0]              src_error,
   input  logic signed [EXP_W-1:0] src_exp,
   input  logic signed [DW-1:0]    src_real,
   input  logic signed [DW-1:0]    src_imag,
   input  logic                    rd_en,
   input  logic [AW-1:0]           rd_addr,
   output logic [2*DW-1:0]         rd_data,
   output logic                    rd_valid,
   output logic                    frame_done,
   input  logic                    frame_ack,
   output logic [AW-1:0]           peak_bin,
   output logic [2*DW-1:0]         peak_pow,
   output logic signed [EXP_W-1:0] frame_exp,
   output logic                    err_flag
);

   localparam int            PW       = 2 * DW;
   localparam logic [AW-1:0] LAST_IDX = AW'(FFT_LEN - 1);
`ifdef DC_EXCLUDE_EN
   localparam logic [AW-1:0] PEAK_FIRST = AW'(1);
`else
   localparam logic [AW-1:0] PEAK_FIRST = AW'(0);
`endif

   sink_state_e             state_q, state_d;
   logic [AW-1:0]           cnt_q, cnt_d;
   logic                    bad_q, bad_d;
   logic                    err_q, err_d;
   logic                    drain_q, drain_d;
   logic                    src_ready_q, src_ready_d;
   logic                    frame_done_q, frame_done_d;
   logic signed [EXP_W-1:0] exp_lat_q, exp_lat_d;
   logic                    commit;
   logic                    accept;
   logic                    pipe_vld;
   logic [AW-1:0]           pipe_idx;

   logic                    vld_p2;
   logic [AW-1:0]           idx_p2;
   logic [PW-1:0]           pow_p2;

   logic [PW-1:0]           run_pow_q, run_pow_d;
   logic [AW-1:0]           run_bin_q, run_bin_d;
   logic [AW-1:0]           peak_bin_q, peak_bin_d;
   logic [PW-1:0]           peak_pow_q, peak_pow_d;
   logic signed [EXP_W-1:0] frame_exp_q, frame_exp_d;
   logic [PW-1:0]           rd_data_q, rd_data_d;
   logic                    rd_valid_q, rd_valid_d;

   logic [PW-1:0]           buf_mem [FFT_LEN];

   assign accept = src_valid & src_ready_q;

   // Frame FSM: decides which beats enter the power pipeline and at which bin.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      bad_d        = bad_q;
      err_d        = err_q;
      drain_d      = 1'b0;
      frame_done_d = 1'b0;
      exp_lat_d    = exp_lat_q;
      commit       = 1'b0;
      pipe_vld     = 1'b0;
      pipe_idx     = cnt_q;

      unique case (state_q)
         IDLE: begin
            if (accept && src_sop) begin
               pipe_vld  = 1'b1;
               pipe_idx  = '0;
               exp_lat_d = src_exp;
               if (src_eop) begin
                  err_d = 1'b1;            // one-beat frame is always short
               end else begin
                  state_d = RECV;
                  cnt_d   = AW'(1);
                  bad_d   = |src_error;
               end
            end
         end
         RECV: begin
            if (accept) begin
               pipe_vld = 1'b1;
               if (src_sop) begin
                  // Restart on the new frame; the old one is abandoned.
                  err_d     = 1'b1;
                  pipe_idx  = '0;
                  exp_lat_d = src_exp;
                  if (src_eop) begin
                     state_d = IDLE;
                  end else begin
                     cnt_d = AW'(1);
                     bad_d = |src_error;
                  end
               end else if (src_eop) begin
                  if (cnt_q == LAST_IDX && !bad_q && src_error == 2'b00) begin
                     state_d = DRAIN;
                  end else begin
                     err_d   = 1'b1;
                     state_d = IDLE;
                  end
               end else if (cnt_q == LAST_IDX) begin
                  err_d   = 1'b1;              // frame overran without eop
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
                  bad_d = bad_q | (|src_error);
               end
            end
         end
         DRAIN: begin
            // Two cycles let the last beat reach the buffer and peak tracker.
            if (drain_q) begin
               state_d      = HOLD;
               frame_done_d = 1'b1;
               commit       = 1'b1;
            end else begin
               drain_d = 1'b1;
            end
         end
         HOLD: begin
            if (frame_ack) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      src_ready_d = (state_d == IDLE) || (state_d == RECV);
   end

   fft_pow_calc #(
      .DW (DW),
      .AW (AW)
   ) u_pow (
      .clk     (sys_clk),
      .rst_n   (sys_rst_n),
      .in_vld  (pipe_vld),
      .in_idx  (pipe_idx),
      .in_re   (src_real),
      .in_im   (src_imag),
      .out_vld (vld_p2),
      .out_idx (idx_p2),
      .out_pow (pow_p2)
   );

   // stage 2 outputs: running peak. Strictly-greater keeps the lowest index on
   // ties; the first tracked bin reseeds the peak so earlier frames never leak.
   always_comb begin
      run_pow_d = run_pow_q;
      run_bin_d = run_bin_q;
      if (vld_p2) begin
         if (idx_p2 == PEAK_FIRST) begin
            run_pow_d = pow_p2;
            run_bin_d = idx_p2;
         end else if (idx_p2 > PEAK_FIRST && pow_p2 > run_pow_q) begin
            run_pow_d = pow_p2;
            run_bin_d = idx_p2;
         end
      end
   end

   // Shadow copy takes the running peak including the final bin retiring now.
   always_comb begin
      peak_bin_d  = commit ? run_bin_d : peak_bin_q;
      peak_pow_d  = commit ? run_pow_d : peak_pow_q;
      frame_exp_d = commit ? exp_lat_q : frame_exp_q;
      rd_valid_d  = rd_en;
      rd_data_d   = rd_en ? buf_mem[rd_addr] : rd_data_q;
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         bad_q        <= 1'b0;
         err_q        <= 1'b0;
         drain_q      <= 1'b0;
         src_ready_q  <= 1'b0;
         frame_done_q <= 1'b0;
         peak_bin_q   <= '0;
         peak_pow_q   <= '0;
         frame_exp_q  <= '0;
         rd_data_q    <= '0;
         rd_valid_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         bad_q        <= bad_d;
         err_q        <= err_d;
         drain_q      <= drain_d;
         src_ready_q  <= src_ready_d;
         frame_done_q <= frame_done_d;
         peak_bin_q   <= peak_bin_d;
         peak_pow_q   <= peak_pow_d;
         frame_exp_q  <= frame_exp_d;
         rd_data_q    <= rd_data_d;
         rd_valid_q   <= rd_valid_d;
      end
   end

   always_ff @(posedge sys_clk) begin
      exp_lat_q <= exp_lat_d;
      run_pow_q <= run_pow_d;
      run_bin_q <= run_bin_d;
      if (vld_p2) begin
         buf_mem[idx_p2] <= pow_p2;
      end
   end

   assign src_ready  = src_ready_q;
   assign frame_done = frame_done_q;
   assign peak_bin   = peak_bin_q;
   assign peak_pow   = peak_pow_q;
   assign frame_exp  = frame_exp_q;
   assign err_flag   = err_q;
   assign rd_data    = rd_data_q;
   assign rd_valid   = rd_valid_q;

endmodule : fft_frame_sink

// File: tb/tb_fft_frame_sink.sv
// -----------------------------------------------------------------------------
// tb_fft_frame_sink
// Self-checking bench for fft_frame_sink with FFT_LEN=16, DW=12. Frames are
// described as arrays of (re, im); the expected powers, peak and exponent are
// computed from those arrays with plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_fft_frame_sink;

   localparam int N     = 16;
   localparam int DW    = 12;
   localparam int EXP_W = 6;
   localparam int AW    = 4;

   logic                    sys_clk = 1'b0;
   logic                    sys_rst_n = 1'b1;
   logic                    src_valid = 1'b0;
   logic                    src_ready;
   logic                    src_sop = 1'b0;
   logic                    src_eop = 1'b0;
   logic [1:0]              src_error = 2'b00;
   logic signed [EXP_W-1:0] src_exp = '0;
   logic signed [DW-1:0]    src_real = '0;
   logic signed [DW-1:0]    src_imag = '0;
   logic                    rd_en = 1'b0;
   logic [AW-1:0]           rd_addr = '0;
   logic [2*DW-1:0]         rd_data;
   logic                    rd_valid;
   logic                    frame_done;
   logic                    frame_ack = 1'b0;
   logic [AW-1:0]           peak_bin;
   logic [2*DW-1:0]         peak_pow;
   logic signed [EXP_W-1:0] frame_exp;
   logic                    err_flag;

   fft_frame_sink #(
      .FFT_LEN (N),
      .DW      (DW),
      .EXP_W   (EXP_W)
   ) dut (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .src_valid  (src_valid),
      .src_ready  (src_ready),
      .src_sop    (src_sop),
      .src_eop    (src_eop),
      .src_error  (src_error),
      .src_exp    (src_exp),
      .src_real   (src_real),
      .src_imag   (src_imag),
      .rd_en      (rd_en),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .rd_valid   (rd_valid),
      .frame_done (frame_done),
      .frame_ack  (frame_ack),
      .peak_bin   (peak_bin),
      .peak_pow   (peak_pow),
      .frame_exp  (frame_exp),
      .err_flag   (err_flag)
   );

   always #5 sys_clk = ~sys_clk;

   int n_chk  = 0;
   int n_pass = 0;

   // frame under construction
   int fr_re [N];
   int fr_im [N];
   int fr_exp;

   // expected held state
   int     m_bin  = 0;
   longint m_pow  = 0;
   int     m_exp  = 0;
   bit     m_err  = 1'b0;
   longint m_bins [N];

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_chk++;
      if (got === want) n_pass++;
      else $display("FAIL %s: observed %0d expected %0d", tag, got, want);
   endtask

   function automatic longint bin_pow(input int k);
      return longint'(fr_re[k]) * fr_re[k] + longint'(fr_im[k]) * fr_im[k];
   endfunction

   // Called when a good frame is delivered: record powers and its peak.
   task automatic model_commit();
      int first;
`ifdef DC_EXCLUDE_EN
      first = 1;
`else
      first = 0;
`endif
      for (int k = 0; k < N; k++) m_bins[k] = bin_pow(k);
      m_bin = first;
      m_pow = m_bins[first];
      for (int k = first + 1; k < N; k++) begin
         if (m_bins[k] > m_pow) begin
            m_pow = m_bins[k];
            m_bin = k;
         end
      end
      m_exp = fr_exp;
   endtask

   task automatic clear_frame();
      for (int k = 0; k < N; k++) begin
         fr_re[k] = 0;
         fr_im[k] = 0;
      end
   endtask

   task automatic random_frame();
      for (int k = 0; k < N; k++) begin
         fr_re[k] = int'($urandom_range(0, 4095)) - 2048;
         fr_im[k] = int'($urandom_range(0, 4095)) - 2048;
      end
      fr_exp = int'($urandom_range(0, 63)) - 32;
   endtask

   // Offer beat k; returns #1 after the edge on which it transferred.
   task automatic send_beat(input int k, input bit sop, input bit eop, input bit err);
      int w;
      repeat ($urandom_range(0, 1)) begin
         @(posedge sys_clk); #1;
      end
      src_real  = DW'(fr_re[k]);
      src_imag  = DW'(fr_im[k]);
      src_exp   = EXP_W'(fr_exp);
      src_sop   = sop;
      src_eop   = eop;
      src_error = err ? 2'b01 : 2'b00;
      src_valid = 1'b1;
      w = 0;
      while (!src_ready && w < 20) begin
         @(posedge sys_clk); #1;
         w++;
      end
      if (!src_ready) check_val("ready_timeout", 0, 1);
      @(posedge sys_clk); #1;
      src_valid = 1'b0;
      src_sop   = 1'b0;
      src_eop   = 1'b0;
      src_error = 2'b00;
   endtask

   task automatic send_frame(input int n_beats, input int eop_at, input bit with_sop, input int err_beat);
      for (int k = 0; k < n_beats; k++)
         send_beat(k, with_sop && k == 0, k == eop_at, k == err_beat);
   endtask

   // Start right after the eop transfer edge. For a good frame, stops in the
   // cycle frame_done is seen (done must appear exactly 2 cycles later).
   task automatic wait_done(input bit expect_done);
      int seen;
      seen = -1;
      for (int c = 0; c < 6 && seen < 0; c++) begin
         if (frame_done) seen = c;
         else begin
            @(posedge sys_clk); #1;
         end
      end
      if (expect_done) check_val("done_latency", (seen < 0) ? 99 : seen, 2);
      else check_val("no_frame_done", (seen < 0) ? 0 : 1, 0);
   endtask

   task automatic check_held();
      check_val("peak_bin", peak_bin, m_bin);
      check_val("peak_pow", peak_pow, m_pow);
      check_val("frame_exp", frame_exp, EXP_W'(m_exp));
      check_val("err_flag", err_flag, m_err);
   endtask

   task automatic read_all();
      for (int k = 0; k < N; k++) begin
         rd_en   = 1'b1;
         rd_addr = AW'(k);
         @(posedge sys_clk); #1;
         check_val($sformatf("rd_valid_%0d", k), rd_valid, 1);
         check_val($sformatf("rd_data_%0d", k), rd_data, m_bins[k]);
      end
      rd_en = 1'b0;
      check_val("ready_in_hold", src_ready, 0);
      @(posedge sys_clk); #1;
      check_val("rd_valid_idle", rd_valid, 0);
   endtask

   task automatic do_ack();
      frame_ack = 1'b1;
      @(posedge sys_clk); #1;
      frame_ack = 1'b0;
      check_val("done_one_cycle", frame_done, 0);
      check_val("ready_after_ack", src_ready, 1);
   endtask

   // mode 0: read back then ack; 1: ack in the frame_done cycle; 2: stay held
   task automatic run_good(input int mode);
      send_frame(N, N - 1, 1'b1, -1);
      model_commit();
      wait_done(1'b1);
      check_held();
      if (mode == 0) begin
         read_all();
         do_ack();
      end else if (mode == 1) begin
         do_ack();
      end
   endtask

   task automatic reset_outputs_zero(input string tag);
      check_val({tag, "_src_ready"}, src_ready, 0);
      check_val({tag, "_err_flag"}, err_flag, 0);
      check_val({tag, "_peak_bin"}, peak_bin, 0);
      check_val({tag, "_peak_pow"}, peak_pow, 0);
      check_val({tag, "_frame_exp"}, frame_exp, 0);
      check_val({tag, "_frame_done"}, frame_done, 0);
      check_val({tag, "_rd_valid"}, rd_valid, 0);
      check_val({tag, "_rd_data"}, rd_data, 0);
   endtask

   initial begin
      // reset
      #2 sys_rst_n = 1'b0;
      repeat (3) @(posedge sys_clk);
      #1;
      reset_outputs_zero("rst");
      sys_rst_n = 1'b1;
      repeat (2) @(posedge sys_clk);
      #1;
      check_val("ready_after_rst", src_ready, 1);

      // ramp: bin k = (k, 0), exp -3
      for (int k = 0; k < N; k++) begin
         fr_re[k] = k;
         fr_im[k] = 0;
      end
      fr_exp = -3;
      run_good(0);

      // most negative sample squared on both parts
      clear_frame();
      fr_re[5] = -2048;
      fr_im[5] = -2048;
      fr_exp   = 7;
      run_good(1);

      // tie between bins 3 and 9
      clear_frame();
      fr_re[3] = 10; fr_im[3] = 10;
      fr_re[9] = 10; fr_im[9] = 10;
      fr_exp   = 0;
      run_good(0);

      // strong DC bin
      clear_frame();
      fr_re[0] = 100;
      fr_re[6] = 3; fr_im[6] = -4;
      fr_exp   = -1;
      run_good(1);

      // random frames
      for (int i = 0; i < 4; i++) begin
         random_frame();
         run_good(i % 2);
      end

      // early eop on the 10th beat: error, held outputs untouched
      random_frame();
      send_frame(10, 9, 1'b1, -1);
      m_err = 1'b1;
      wait_done(1'b0);
      check_held();
      random_frame();
      run_good(0);

      // core error on one beat of an otherwise well-formed frame
      random_frame();
      send_frame(N, N - 1, 1'b1, 4);
      wait_done(1'b0);
      check_held();

      // back-pressure while a frame is held
      random_frame();
      run_good(2);
      src_valid = 1'b1;
      src_sop   = 1'b1;
      for (int c = 0; c < 3; c++) begin
         check_val("ready_held", src_ready, 0);
         @(posedge sys_clk); #1;
      end
      src_valid = 1'b0;
      src_sop   = 1'b0;
      do_ack();
      random_frame();
      run_good(0);

      // reset in the middle of a frame
      random_frame();
      send_frame(6, -1, 1'b1, -1);
      #3 sys_rst_n = 1'b0;
      #1;
      reset_outputs_zero("midrst");
      m_bin = 0; m_pow = 0; m_exp = 0; m_err = 1'b0;
      @(posedge sys_clk); #1;
      sys_rst_n = 1'b1;
      random_frame();
      send_frame(N, N - 1, 1'b0, -1);
      wait_done(1'b0);
      check_held();
      random_frame();
      run_good(0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule : tb_fft_frame_sink
